// File: rtl/fixed_point_accumulator.sv
// Guard-extended accumulator: bias + NUM_TERMS signed products -> one saturated result.
// Optional FIXED_ACC_RELU_EN clamps negative results to zero after saturation.
module fixed_point_accumulator #(
    parameter int SIZE      = 32,
    parameter int INT_PART  = 15,
    parameter int NUM_TERMS = 4,
    parameter int GUARD     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [SIZE-1:0] IN,
    input  logic [SIZE-1:0] BIAS,
    output logic            busy,
    output logic            valid_out,
    output logic [SIZE-1:0] OUT,
    output logic            sat_flag
);

    localparam int AW = SIZE + GUARD;
    localparam int CW = $clog2(NUM_TERMS);

    generate
        if (NUM_TERMS < 2 || INT_PART > SIZE - 1 || NUM_TERMS + 1 >= 2 ** GUARD) begin : g_bad_cfg
            $error("fixed_point_accumulator: unsupported parameter set");
        end
    endgenerate

    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_acc;
    logic [SIZE-1:0] r_out;
    logic            r_valid;
    logic            r_busy;
    logic            r_sat;

    logic [AW-1:0]   w_in_ext;
    logic [AW-1:0]   w_bias_ext;
    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_sum;
    logic [GUARD:0]  w_hi;
    logic            w_first;
    logic            w_last;
    logic            w_ovf;
    logic [SIZE-1:0] w_sat;
    logic [SIZE-1:0] w_res;

    assign w_in_ext   = {{GUARD{IN[SIZE-1]}}, IN};
    assign w_bias_ext = {{GUARD{BIAS[SIZE-1]}}, BIAS};
    assign w_first    = (r_count == '0);
    assign w_last     = (r_count == CW'(NUM_TERMS - 1));
    assign w_base     = w_first ? w_bias_ext : r_acc;
    assign w_sum      = w_base + w_in_ext;

    // Result fits in SIZE bits only when the guard bits all copy the sign bit.
    assign w_hi  = w_sum[AW-1:SIZE-1];
    assign w_ovf = !((&w_hi) || !(|w_hi));

    always_comb begin
        w_sat = w_sum[SIZE-1:0];
        if (w_ovf) begin
            w_sat = w_sum[AW-1] ? {1'b1, {(SIZE-1){1'b0}}}
                                : {1'b0, {(SIZE-1){1'b1}}};
        end
    end

`ifdef FIXED_ACC_RELU_EN
    assign w_res = w_sat[SIZE-1] ? '0 : w_sat;
`else
    assign w_res = w_sat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (valid_in) begin
                if (w_last) begin
                    r_out   <= w_res;
                    r_valid <= 1'b1;
                    r_sat   <= w_ovf;
                    r_acc   <= '0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end else begin
                    r_acc   <= w_sum;
                    r_count <= r_count + CW'(1);
                    r_busy  <= 1'b1;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign valid_out = r_valid;
    assign OUT       = r_out;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Randomized bench for fixed_point_accumulator against an arithmetic reference model,
// plus directed vectors with literal expectations.
module tb_fixed_point_accumulator;

    localparam int SIZE = 32;
    localparam int NT   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_in;
    logic [SIZE-1:0] IN;
    logic [SIZE-1:0] BIAS;
    logic            busy;
    logic            valid_out;
    logic [SIZE-1:0] OUT;
    logic            sat_flag;

    fixed_point_accumulator #(
        .SIZE(SIZE), .INT_PART(15), .NUM_TERMS(NT), .GUARD(8)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .IN(IN), .BIAS(BIAS),
        .busy(busy), .valid_out(valid_out), .OUT(OUT), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit cmp_en = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: whole-vector sum in 64-bit integers, clamped to SIZE bits.
    int              m_terms = 0;
    longint          m_sum = 0;
    longint          m_t;
    longint          m_res;
    bit              m_valid = 0;
    bit              m_busy = 0;
    bit              m_sat = 0;
    logic [SIZE-1:0] m_out = '0;
    localparam longint SMAX = (64'sd1 <<< (SIZE - 1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (SIZE - 1));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_terms = 0; m_sum = 0; m_valid = 0;
            m_out = '0; m_sat = 0;
        end else begin
            m_valid = 0;
            if (valid_in) begin
                m_t = $signed(IN);
                if (m_terms == 0) m_sum = $signed(BIAS);
                m_sum = m_sum + m_t;
                m_terms++;
                if (m_terms == NT) begin
                    m_sat = (m_sum > SMAX) || (m_sum < SMIN);
                    m_res = (m_sum > SMAX) ? SMAX : (m_sum < SMIN) ? SMIN : m_sum;
`ifdef FIXED_ACC_RELU_EN
                    if (m_res < 0) m_res = 0;
`endif
                    m_out   = m_res[SIZE-1:0];
                    m_valid = 1;
                    m_terms = 0;
                end
            end
        end
        m_busy = (m_terms != 0);
    end

    logic [SIZE-1:0] got[$];
    int              got_cyc[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid_out", 64'(valid_out), 64'(m_valid));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("OUT", 64'(OUT), 64'(m_out));
            chk("sat_flag", 64'(sat_flag), 64'(m_sat));
            if (valid_out) begin
                got.push_back(OUT);
                got_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic [SIZE-1:0] qv(int i);
        return (got.size() > i) ? got[i] : 'x;
    endfunction

    task automatic drive(bit v, logic [SIZE-1:0] d, logic [SIZE-1:0] b);
        @(posedge clk);
        #1;
        rst = 0; valid_in = v; IN = d; BIAS = b;
    endtask

    task automatic do_rst();
        @(posedge clk);
        #1;
        rst = 1; valid_in = 1'b1; IN = 32'h0001_0000; BIAS = '0;
    endtask

    task automatic settle();
        drive(0, '0, '0);
        repeat (2) drive(0, '0, '0);
        @(negedge clk);
        #1;
    endtask

    task automatic vec(logic [SIZE-1:0] d, logic [SIZE-1:0] b);
        for (int j = 0; j < NT; j++) drive(1, d, b);
    endtask

    logic [SIZE-1:0] rv;
    int              r;

    initial begin
        rst = 1; valid_in = 0; IN = '0; BIAS = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset OUT", 64'(OUT), 64'h0);
        chk("reset valid_out", 64'(valid_out), 64'h0);
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset sat_flag", 64'(sat_flag), 64'h0);
        cmp_en = 1;

        // Basic sum: 0.5 + 4 * 1.0
        got.delete(); got_cyc.delete();
        vec(32'h0001_0000, 32'h0000_8000);
        settle();
        chk("basic count", 64'(got.size()), 64'd1);
        chk("basic OUT", 64'(qv(0)), 64'h0004_8000);
        chk("basic sat", 64'(sat_flag), 64'h0);
        chk("basic busy", 64'(busy), 64'h0);

        // Gapped input with busy held between terms
        got.delete(); got_cyc.delete();
        for (int i = 0; i < NT; i++) begin
            drive(1, 32'h0001_0000, 32'h0000_8000);
            if (i < NT - 1) begin
                repeat (2) begin
                    drive(0, '0, '0);
                    @(negedge clk);
                    #1;
                    chk("gap busy", 64'(busy), 64'h1);
                end
            end
        end
        settle();
        chk("gap count", 64'(got.size()), 64'd1);
        chk("gap OUT", 64'(qv(0)), 64'h0004_8000);

        // Back-to-back vectors
        got.delete(); got_cyc.delete();
        for (int k = 1; k <= 3; k++) vec(32'(k) << 16, '0);
        settle();
        chk("b2b count", 64'(got.size()), 64'd3);
        chk("b2b OUT0", 64'(qv(0)), 64'h0004_0000);
        chk("b2b OUT1", 64'(qv(1)), 64'h0008_0000);
        chk("b2b OUT2", 64'(qv(2)), 64'h000C_0000);
        if (got_cyc.size() == 3) begin
            chk("b2b spacing0", 64'(got_cyc[1] - got_cyc[0]), 64'd4);
            chk("b2b spacing1", 64'(got_cyc[2] - got_cyc[1]), 64'd4);
        end

        // Positive and negative saturation
        got.delete(); got_cyc.delete();
        vec(32'h7000_0000, '0);
        settle();
        chk("pos sat OUT", 64'(qv(0)), 64'h7FFF_FFFF);
        chk("pos sat flag", 64'(sat_flag), 64'h1);
        got.delete(); got_cyc.delete();
        vec(32'h9000_0000, '0);
        settle();
`ifdef FIXED_ACC_RELU_EN
        chk("neg sat OUT", 64'(qv(0)), 64'h0000_0000);
`else
        chk("neg sat OUT", 64'(qv(0)), 64'h8000_0000);
`endif
        chk("neg sat flag", 64'(sat_flag), 64'h1);

        // Reset mid-vector, with valid_in high during reset
        got.delete(); got_cyc.delete();
        drive(1, 32'h0001_0000, '0);
        drive(1, 32'h0001_0000, '0);
        do_rst();
        vec(32'h0000_4000, '0);
        settle();
        chk("abort count", 64'(got.size()), 64'd1);
        chk("abort OUT", 64'(qv(0)), 64'h0001_0000);

        // Negative sum without saturation: -1.0 + 4 * -0.5
        got.delete(); got_cyc.delete();
        vec(32'hFFFF_8000, 32'hFFFF_0000);
        settle();
`ifdef FIXED_ACC_RELU_EN
        chk("neg OUT", 64'(qv(0)), 64'h0000_0000);
`else
        chk("neg OUT", 64'(qv(0)), 64'hFFFD_0000);
`endif
        chk("neg sat", 64'(sat_flag), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 3))
                0: rv = $urandom;
                1: rv = 32'($urandom_range(0, 32'h0003_FFFF)) ^
                        ($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0);
                2: rv = $urandom_range(0, 1) ? (32'h7F00_0000 | 32'($urandom_range(0, 32'hFFFFFF)))
                                             : (32'h8000_0000 | 32'($urandom_range(0, 32'hFFFFFF)));
                default: rv = $urandom;
            endcase
            if (r < 1) do_rst();
            else drive(r < 75, rv, $urandom);
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
